// File: rtl/aes32_pkg.sv
// Shared AES-128 constants, FSM state type and byte-level helpers
// for the word-serial two-block encryption core.
package aes32_pkg;

    localparam int NUM_ROUNDS = 10;
    localparam int WORDS      = 4;
    localparam int BLOCKS     = 2;
    localparam int RUN_CYCLES = 88;
    localparam int OUT_CYCLES = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_OUT
    } state_t;

    // Forward S-box, element 0 is the leftmost byte.
    localparam logic [0:255][7:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[x];
    endfunction

    // Multiply by x in GF(2^8) modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_col_xform.sv
// One AES column: SubBytes on four already-shifted bytes, then MixColumns
// when mix_en is set (cleared for the final round).
module aes_col_xform
    import aes32_pkg::*;
(
    input  logic [7:0]  b0,
    input  logic [7:0]  b1,
    input  logic [7:0]  b2,
    input  logic [7:0]  b3,
    input  logic        mix_en,
    output logic [31:0] col
);

    logic [7:0] s0, s1, s2, s3;
    logic [7:0] m0, m1, m2, m3;

    // Substitute each byte, mix the column, select mixed or plain result.
    always_comb begin
        s0 = sbox(b0);
        s1 = sbox(b1);
        s2 = sbox(b2);
        s3 = sbox(b3);
        m0 = xtime(s0) ^ xtime(s1) ^ s1 ^ s2 ^ s3;
        m1 = s0 ^ xtime(s1) ^ xtime(s2) ^ s2 ^ s3;
        m2 = s0 ^ s1 ^ xtime(s2) ^ xtime(s3) ^ s3;
        m3 = xtime(s0) ^ s0 ^ s1 ^ s2 ^ xtime(s3);
        col = mix_en ? {m0, m1, m2, m3} : {s0, s1, s2, s3};
    end

endmodule

// File: rtl/aes32_dsp_8p.sv
// Two-block interleaved AES-128 encryptor, one 32-bit column per cycle.
// Slots 0-3 of the state buffer hold block A, slots 4-7 block B. Round keys
// arrive on KEY in lockstep with the column being produced.
module aes32_dsp_8p
    import aes32_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [31:0] DIN,
    input  logic [31:0] KEY,
    output logic        DONE,
    output logic [31:0] DOUT
);

    localparam int SLOTS = WORDS * BLOCKS;

    state_t      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        start_prev_q, start_prev_d;
    logic        done_q, done_d;
    logic [31:0] dout_q, dout_d;

    logic [31:0]  sbuf_q [SLOTS];
    logic [31:0]  sbuf_d [SLOTS];
    logic [127:0] snap_q, snap_d;

    logic        start_rise;
    logic        active;
    logic [6:0]  n_idx;
    logic [3:0]  rnd_idx;
    logic [2:0]  slot_idx;
    logic        blk;
    logic [1:0]  col_idx;
    logic [31:0] src_w [WORDS];
    logic [7:0]  src_b [WORDS];
    logic [31:0] xf_col;

    // Decode the schedule position. The edge that detects START is itself
    // cycle 0, so in RUN the counter already holds the cycle index 1..87.
    always_comb begin
        start_rise   = START & ~start_prev_q;
        start_prev_d = START;
        active       = (state_q == ST_RUN) || ((state_q == ST_IDLE) && start_rise);
        n_idx        = (state_q == ST_RUN) ? cnt_q : 7'd0;
        rnd_idx      = n_idx[6:3];
        slot_idx     = n_idx[2:0];
        blk          = n_idx[2];
        col_idx      = n_idx[1:0];
    end

    // Gather ShiftRows sources: column 0 reads the live buffer (nothing of
    // this round written yet), columns 1-3 read the snapshot taken at column 0.
    always_comb begin
        for (int j = 0; j < WORDS; j++) begin
            if (col_idx == 2'd0) begin
                src_w[j] = sbuf_q[{blk, 2'(j)}];
            end else begin
                src_w[j] = snap_q[127 - 32 * j -: 32];
            end
        end
        for (int i = 0; i < WORDS; i++) begin
            src_b[i] = src_w[2'(col_idx + 2'(i))][31 - 8 * i -: 8];
        end
    end

    aes_col_xform u_xform (
        .b0     (src_b[0]),
        .b1     (src_b[1]),
        .b2     (src_b[2]),
        .b3     (src_b[3]),
        .mix_en (rnd_idx != 4'(NUM_ROUNDS)),
        .col    (xf_col)
    );

    // Next buffer contents: round 0 loads DIN^KEY, later rounds write the
    // transformed column ^ KEY; the block snapshot refreshes at column 0.
    always_comb begin
        sbuf_d = sbuf_q;
        snap_d = snap_q;
        if (active) begin
            if (col_idx == 2'd0) begin
                snap_d = {sbuf_q[{blk, 2'd0}], sbuf_q[{blk, 2'd1}],
                          sbuf_q[{blk, 2'd2}], sbuf_q[{blk, 2'd3}]};
            end
            if (rnd_idx == 4'd0) begin
                sbuf_d[slot_idx] = DIN ^ KEY;
            end else begin
                sbuf_d[slot_idx] = xf_col ^ KEY;
            end
        end
    end

    // Control FSM next state and registered output values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        dout_d  = 32'h0;
        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d = ST_RUN;
                    cnt_d   = 7'd1;
                end
            end
            ST_RUN: begin
                if (cnt_q == 7'(RUN_CYCLES - 1)) begin
                    state_d = ST_OUT;
                    cnt_d   = 7'd0;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            ST_OUT: begin
                done_d = 1'b1;
                dout_d = sbuf_q[cnt_q[2:0]];
                if (cnt_q == 7'(OUT_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = 7'd0;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 7'd0;
            end
        endcase
    end

    // Control and output registers; reset aborts any operation at once.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 7'd0;
            start_prev_q <= 1'b0;
            done_q       <= 1'b0;
            dout_q       <= 32'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            start_prev_q <= start_prev_d;
            done_q       <= done_d;
            dout_q       <= dout_d;
        end
    end

    // State buffer and snapshot carry data only and need no reset.
    always_ff @(posedge CLK) begin
        sbuf_q <= sbuf_d;
        snap_q <= snap_d;
    end

    assign DONE = done_q;
    assign DOUT = dout_q;

endmodule

// File: tb/tb_aes32_dsp_8p.sv
// Bench for aes32_dsp_8p: drives the fixed 88-cycle word schedule, queues
// expected ciphertext words and checks the 8-cycle output burst.
module tb_aes32_dsp_8p;

    logic        CLK;
    logic        RST;
    logic        START;
    logic [31:0] DIN;
    logic [31:0] KEY;
    logic        DONE;
    logic [31:0] DOUT;

    int n_pass;
    int n_checks;

    logic [31:0]  exp_q [$];
    logic [7:0]   sbox_t [256];
    logic [127:0] rk [11];

    localparam logic [128-1:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [128-1:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [128-1:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

    aes32_dsp_8p dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .DIN   (DIN),
        .KEY   (KEY),
        .DONE  (DONE),
        .DOUT  (DOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        return (b << k) | (b >> (8 - k));
    endfunction

    // S-box from the field inverse plus the affine map.
    task automatic init_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic key_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]}
                    ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] st;
        st = pt ^ rk[0];
        for (int r = 1; r <= 10; r++) begin
            for (int k = 0; k < 16; k++) s[k] = st[127 - 8 * k -: 8];
            for (int c = 0; c < 4; c++)
                for (int i = 0; i < 4; i++)
                    t[4 * c + i] = sbox_t[s[4 * ((c + i) % 4) + i]];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4 * c]; a1 = t[4 * c + 1]; a2 = t[4 * c + 2]; a3 = t[4 * c + 3];
                    t[4 * c]     = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    t[4 * c + 1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    t[4 * c + 2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    t[4 * c + 3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int k = 0; k < 16; k++) st[127 - 8 * k -: 8] = t[k];
            st = st ^ rk[r];
        end
        return st;
    endfunction

    // ---------------- stimulus ----------------
    task automatic apply_reset();
        @(negedge CLK);
        RST = 1'b1; START = 1'b0; DIN = 32'h0; KEY = 32'h0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // Drives cycles 0..stop_n-1 of an operation; START is left high.
    task automatic drive_op(input logic [127:0] a, input logic [127:0] b,
                            input logic [127:0] ca, input logic [127:0] cb,
                            input int stop_n, input bit push);
        int r, s, c;
        if (push) begin
            for (int k = 0; k < 4; k++) exp_q.push_back(ca[127 - 32 * k -: 32]);
            for (int k = 0; k < 4; k++) exp_q.push_back(cb[127 - 32 * k -: 32]);
        end
        @(negedge CLK);
        START = 1'b0;
        for (int n = 0; n < stop_n; n++) begin
            @(negedge CLK);
            r = n / 8; s = n % 8; c = s % 4;
            START = 1'b1;
            KEY = rk[r][127 - 32 * c -: 32];
            if (n < 8) DIN = (s < 4) ? a[127 - 32 * c -: 32] : b[127 - 32 * c -: 32];
            else       DIN = $urandom;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RST = 1'b1; START = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        n_checks++;
        if (DONE !== 1'b0) $display("FAIL reset_done: DONE=%b want 0", DONE);
        else n_pass++;
        n_checks++;
        if (DOUT !== 32'h0) $display("FAIL reset_dout: DOUT=%h want 00000000", DOUT);
        else n_pass++;
        // START rising on the same edge as RST must not launch an operation.
        START = 1'b1;
        @(negedge CLK);
        RST = 1'b0; START = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            n_checks++;
            if (DONE !== 1'b0 || DOUT !== 32'h0)
                $display("FAIL reset_prio[%0d]: DONE=%b DOUT=%h want 0/00000000", i, DONE, DOUT);
            else n_pass++;
        end
    endtask

    task automatic test_fips();
        logic        exp_d;
        logic [31:0] w;
        key_expand(FIPS_KEY);
        drive_op(FIPS_PT, FIPS_PT, FIPS_CT, FIPS_CT, 88, 1'b1);
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            exp_d = (i >= 1 && i <= 8);
            n_checks++;
            if (DONE !== exp_d) $display("FAIL fips_done[%0d]: DONE=%b want %b", i, DONE, exp_d);
            else n_pass++;
            n_checks++;
            if (DONE === 1'b1) begin
                if (exp_q.size() == 0) $display("FAIL fips_underflow[%0d]: DOUT=%h want none", i, DOUT);
                else begin
                    w = exp_q.pop_front();
                    if (DOUT !== w) $display("FAIL fips_dout[%0d]: DOUT=%h want %h", i, DOUT, w);
                    else n_pass++;
                end
            end else if (DOUT !== 32'h0) $display("FAIL fips_idle_dout[%0d]: DOUT=%h want 00000000", i, DOUT);
            else n_pass++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL fips_leftover: %0d words unread want 0", exp_q.size());
            exp_q.delete();
        end else n_pass++;
        START = 1'b0;
    endtask

    task automatic test_zero_key();
        logic         exp_d;
        logic [31:0]  w;
        logic [127:0] a, b, ca, cb, one;
        int           p;
        one = 128'h1;
        key_expand(128'h0);
        for (int t = 0; t < 129; t++) begin
            if (t == 0) begin
                a = 128'h0; b = 128'h0;
                ca = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e; cb = ca;
            end else if (t == 1) begin
                a = 128'h80000000000000000000000000000000;
                b = 128'h40000000000000000000000000000000;
                ca = 128'h3ad78e726c1ec02b7ebfe92b23d9ec34;
                cb = 128'h45bc707d29e8204d88dfba2f0b0cad9b;
            end else begin
                p = t - 1;
                a = one << (127 - p);
                b = one << (127 - ((p + 1) % 128));
                ca = aes_enc(a); cb = aes_enc(b);
            end
            apply_reset();
            drive_op(a, b, ca, cb, 88, 1'b1);
            for (int i = 0; i < 12; i++) begin
                @(negedge CLK);
                exp_d = (i >= 1 && i <= 8);
                n_checks++;
                if (DONE !== exp_d) $display("FAIL zk%0d_done[%0d]: DONE=%b want %b", t, i, DONE, exp_d);
                else n_pass++;
                n_checks++;
                if (DONE === 1'b1) begin
                    if (exp_q.size() == 0) $display("FAIL zk%0d_underflow[%0d]: DOUT=%h want none", t, i, DOUT);
                    else begin
                        w = exp_q.pop_front();
                        if (DOUT !== w) $display("FAIL zk%0d_dout[%0d]: DOUT=%h want %h", t, i, DOUT, w);
                        else n_pass++;
                    end
                end else if (DOUT !== 32'h0) $display("FAIL zk%0d_idle_dout[%0d]: DOUT=%h want 00000000", t, i, DOUT);
                else n_pass++;
            end
            if (exp_q.size() != 0) begin
                n_checks++;
                $display("FAIL zk%0d_leftover: %0d words unread want 0", t, exp_q.size());
                exp_q.delete();
            end
        end
        START = 1'b0;
    endtask

    task automatic test_reset_mid();
        key_expand(FIPS_KEY);
        drive_op(FIPS_PT, FIPS_PT, FIPS_CT, FIPS_CT, 40, 1'b0);
        @(negedge CLK);
        RST = 1'b1; START = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(negedge CLK);
            n_checks++;
            if (DONE !== 1'b0 || DOUT !== 32'h0)
                $display("FAIL abort[%0d]: DONE=%b DOUT=%h want 0/00000000", i, DONE, DOUT);
            else n_pass++;
        end
    endtask

    task automatic test_start_held();
        logic        exp_d;
        logic [31:0] w;
        int          bursts;
        bursts = 0;
        key_expand(FIPS_KEY);
        drive_op(FIPS_PT, FIPS_PT, FIPS_CT, FIPS_CT, 88, 1'b1);
        for (int i = 0; i < 212; i++) begin
            @(negedge CLK);
            exp_d = (i >= 1 && i <= 8);
            if (DONE === 1'b1) bursts++;
            n_checks++;
            if (DONE !== exp_d) $display("FAIL held_done[%0d]: DONE=%b want %b", i, DONE, exp_d);
            else n_pass++;
            n_checks++;
            if (DONE === 1'b1) begin
                if (exp_q.size() == 0) $display("FAIL held_underflow[%0d]: DOUT=%h want none", i, DOUT);
                else begin
                    w = exp_q.pop_front();
                    if (DOUT !== w) $display("FAIL held_dout[%0d]: DOUT=%h want %h", i, DOUT, w);
                    else n_pass++;
                end
            end else if (DOUT !== 32'h0) $display("FAIL held_idle_dout[%0d]: DOUT=%h want 00000000", i, DOUT);
            else n_pass++;
        end
        n_checks++;
        if (bursts != 8) $display("FAIL held_burst_len: %0d DONE cycles want 8", bursts);
        else n_pass++;
        exp_q.delete();
        START = 1'b0;
    endtask

    initial begin
        RST = 1'b1; START = 1'b0; DIN = 32'h0; KEY = 32'h0;
        n_pass = 0; n_checks = 0;
        init_sbox();
        test_reset();
        test_fips();
        test_zero_key();
        test_reset_mid();
        test_fips();
        test_start_held();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
